spi_flash_responder: RTL
========================

// Module: spi_flash_responder
// PURPOSE
//  Synthesizable SPI-mode-0 flash responder: the serial-memory end of the SPI link driven by topcore_tecriscv
//  (MISO/MOSI/SCLK/SCS). Replaces the behavioural IS25WP032D model in FPGA/emulation builds.
//  Serves READ (0x03), RDSR (0x05) and RDID (0x9F) from an internal byte RAM, loaded via a parallel backdoor port.
//  Oversamples SCLK/SCS/MOSI in the clk domain; no SCLK-clocked logic.
// PARAMETERS
//  ADDR_W    12        RAM address width; size = 2**ADDR_W bytes; upper bits of the 24-bit SPI address are ignored
//  JEDEC_ID  24'h9D7016 bytes returned by RDID, MSB byte first
//  SYNC_STG  2         synchronizer flops on SCLK, SCS, MOSI (>=2)
// PORTS
//  clk       in   1       system clock; must be >= 8x SCLK, with SCLK high and low phases each >= 4 clk
//  reset     in   1       synchronous, active-high
//  SCLK      in   1       SPI clock from master, idle low (mode 0)
//  SCS       in   1       chip select, active low
//  MOSI      in   1       serial data from master, MSB first
//  MISO      out  1       serial data to master, MSB first
//  ld_we     in   1       backdoor RAM write strobe
//  ld_addr   in   ADDR_W  backdoor write address
//  ld_data   in   8       backdoor write data
//  busy      out  1       high while a command is in progress (state != IDLE)
//  cmd_err   out  1       one-cycle pulse when an unsupported opcode is received
// BEHAVIOUR
//  - Reset: state=IDLE, MISO=0, busy=0, cmd_err=0, bit/byte counters=0, address=0. RAM contents are not cleared.
//  - Inputs pass through SYNC_STG flops, then a 1-flop edge detector.
//    rise/fall = edge of synced SCLK while synced SCS=0.
//  - MOSI is sampled on rise. MISO is updated on the clk cycle after fall detection
//    (total lag SYNC_STG+1 clk from pin edge).
//  - SCS high (synced) in any state -> IDLE next cycle; MISO=0; partial byte discarded;
//    a pending cmd_err is still issued.
//  - FSM:
//    IDLE   -> CMD on synced SCS falling.
//    CMD    shifts 8 bits; on 8th rise: 0x03 -> ADDR; 0x05 -> STAT; 0x9F -> ID;
//           other -> IGN and pulse cmd_err for 1 clk.
//    ADDR   shifts 24 bits; on 24th rise addr <= addr[ADDR_W-1:0] and RAM read issued (1-clk sync read) -> DATA.
//    DATA   on each fall shift out current byte MSB first. After the 8th bit of a byte has been driven,
//           addr increments mod 2**ADDR_W (wrap 2**ADDR_W-1 -> 0) and the next byte is prefetched.
//           Streams until SCS high.
//    STAT   returns 8'h00 (WIP=0, WEL=0) repeatedly until SCS high.
//    ID     returns JEDEC_ID[23:16], [15:8], [7:0], then 8'h00 repeatedly.
//    IGN    MISO=0, ignore all edges until SCS high.
//  - First output bit: the fall following the last command/address rise drives bit7 of the first response byte.
//    Prefetch completes within 2 clk, well inside the >=4-clk low phase.
//  - MISO=0 in IDLE, CMD, ADDR, IGN.
//  - Backdoor: ld_we writes ld_data at ld_addr in the same cycle, accepted in any state.
//    If it coincides with a prefetch of the same address, the prefetch returns the old byte.
//  - busy = (state != IDLE); it drops the cycle after synced SCS rises.
//  - Reset asserted mid-transfer: all state to reset values next clk. A transfer already in progress
//    is ignored (IGN-equivalent) until SCS goes high then low again.
// TESTING
//  1. Backdoor-load 0x010=A5, 0x011=3C. Send 03 00 00 10 + 16 clocks -> MISO bytes A5, 3C; busy 1 until SCS high.
//  2. ADDR_W=12: load 0xFFF=11, 0x000=22. READ at 00 0F FF, 16 clocks -> 11, 22 (wrap).
//     Address FF F0 10 reads byte 0x010.
//  3. Send 9F + 32 clocks -> 9D, 70, 16, 00. Send 05 + 16 clocks -> 00, 00.
//  4. Opcode AB + 8 clocks -> MISO stays 0; cmd_err high exactly 1 clk; busy clears after SCS high.
//  5. Raise SCS after 12 address bits, then send 03 00 00 10 -> correct A5. No residue from the aborted command.
//  6. Assert reset for 1 clk mid-DATA -> MISO=0, busy=0 next cycle.
//     RAM contents are retained; the next clean READ returns the preloaded data.

Source files
------------

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial flash responder serving READ/RDSR/RDID from a backdoor-loaded byte RAM.
// SCLK/SCS/MOSI are oversampled in the clk domain; there is no SCLK-clocked logic.
module spi_flash_responder #(
  parameter int unsigned ADDR_W   = 12,
  parameter logic [23:0] JEDEC_ID = 24'h9D7016,
  parameter int unsigned SYNC_STG = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              SCLK,
  input  logic              SCS,
  input  logic              MOSI,
  output logic              MISO,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              busy,
  output logic              cmd_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    STAT = 3'd4,
    ID   = 3'd5,
    IGN  = 3'd6
  } state_t;

  logic [SYNC_STG-1:0] sclk_sync, scs_sync, mosi_sync;
  logic                sclk_s, scs_s, mosi_s;
  logic                sclk_d, scs_d;
  logic                rise, fall, scs_fall;

  state_t              state, state_n;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_n;
  logic [22:0]         shift, shift_n;
  logic [ADDR_W-1:0]   addr, addr_n;
  logic [1:0]          id_idx, id_idx_n;
  logic                miso_q, miso_n;
  logic                busy_q, cmd_err_q, cmd_err_n;

  logic [23:0]         rise_word;
  logic [7:0]          resp_byte;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic [7:0]          rd_data;
  logic [7:0]          mem [DEPTH];
  logic                unused_bits;

  // Synchronizers and edge detector; reset to 0 so a live transfer cannot look like a new SCS fall
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      scs_sync  <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      scs_d     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STG-2:0], SCLK};
      scs_sync  <= {scs_sync[SYNC_STG-2:0], SCS};
      mosi_sync <= {mosi_sync[SYNC_STG-2:0], MOSI};
      sclk_d    <= sclk_s;
      scs_d     <= scs_s;
    end
  end

  assign sclk_s   = sclk_sync[SYNC_STG-1];
  assign scs_s    = scs_sync[SYNC_STG-1];
  assign mosi_s   = mosi_sync[SYNC_STG-1];
  assign rise     = sclk_s & ~sclk_d & ~scs_s;
  assign fall     = ~sclk_s & sclk_d & ~scs_s;
  assign scs_fall = ~scs_s & scs_d;

  assign rise_word   = {shift, mosi_s};
  assign unused_bits = rise_word[23];

  // Byte RAM: backdoor write plus 1-cycle synchronous read (read-before-write on collision)
  always_ff @(posedge clk) begin
    if (ld_we) mem[ld_addr] <= ld_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  // Response byte for the current response state
  always_comb begin
    resp_byte = 8'h00;
    case (state)
      DATA: resp_byte = rd_data;
      ID: begin
        case (id_idx)
          2'd0:    resp_byte = JEDEC_ID[23:16];
          2'd1:    resp_byte = JEDEC_ID[15:8];
          2'd2:    resp_byte = JEDEC_ID[7:0];
          default: resp_byte = 8'h00;
        endcase
      end
      default: resp_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      addr      <= '0;
      id_idx    <= '0;
      miso_q    <= 1'b0;
      busy_q    <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      addr      <= addr_n;
      id_idx    <= id_idx_n;
      miso_q    <= miso_n;
      busy_q    <= (state_n != IDLE);
      cmd_err_q <= cmd_err_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    addr_n    = addr;
    id_idx_n  = id_idx;
    miso_n    = miso_q;
    cmd_err_n = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = addr;

    case (state)
      IDLE: begin
        miso_n = 1'b0;
        if (scs_fall) begin
          state_n   = CMD;
          bit_cnt_n = '0;
        end
      end
      CMD: begin
        miso_n = 1'b0;
        if (rise) begin
          shift_n   = rise_word[22:0];
          bit_cnt_n = bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(7)) begin
            bit_cnt_n = '0;
            case (rise_word[7:0])
              8'h03: state_n = ADDR;
              8'h05: state_n = STAT;
              8'h9F: begin
                state_n  = ID;
                id_idx_n = '0;
              end
              default: begin
                state_n   = IGN;
                cmd_err_n = 1'b1;
              end
            endcase
          end
        end
      end
      ADDR: begin
        miso_n = 1'b0;
        if (rise) begin
          shift_n   = rise_word[22:0];
          bit_cnt_n = bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(23)) begin
            bit_cnt_n = '0;
            addr_n    = rise_word[ADDR_W-1:0];
            rd_en     = 1'b1;
            rd_addr   = rise_word[ADDR_W-1:0];
            state_n   = DATA;
          end
        end
      end
      DATA, STAT, ID: begin
        if (fall) begin
          miso_n    = resp_byte[~bit_cnt[2:0]];
          bit_cnt_n = bit_cnt + CNT_W'(1);
          // Byte fully driven: advance to the next response byte
          if (bit_cnt[2:0] == 3'd7) begin
            bit_cnt_n = '0;
            if (state == DATA) begin
              addr_n  = addr + ADDR_W'(1);
              rd_en   = 1'b1;
              rd_addr = addr + ADDR_W'(1);
            end
            if (state == ID && id_idx != 2'd3) id_idx_n = id_idx + 2'd1;
          end
        end
      end
      IGN: miso_n = 1'b0;
      default: begin
        state_n = IDLE;
        miso_n  = 1'b0;
      end
    endcase

    // Deselect aborts any transfer, discarding partial bytes
    if (scs_s && state != IDLE) begin
      state_n   = IDLE;
      miso_n    = 1'b0;
      bit_cnt_n = '0;
    end
  end

  assign MISO    = miso_q;
  assign busy    = busy_q;
  assign cmd_err = cmd_err_q;

endmodule
